fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'd0, giving the PC value loaded on reset.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port Freeze  input  1  downstream stall; an instruction with Valid_out=1 is consumed on a cycle with Freeze=0.
REQ-005 The block SHALL have port Branch_Taken  input  1  single-cycle redirect strobe.
REQ-006 The block SHALL have port Branch_Address  input  32  redirect target, sampled when Branch_Taken=1.
REQ-007 The block SHALL have port Mem_Ready  input  1  instruction memory completion; meaningful only while Mem_Req=1.
REQ-008 The block SHALL have port Mem_Instruction  input  32  memory read data, valid with Mem_Ready.
REQ-009 The block SHALL have port Mem_Req  output  1  memory request, registered.
REQ-010 The block SHALL have port Mem_Address  output  32  request address, registered.
REQ-011 The block SHALL have port Instruction_out  output  32  buffered instruction.
REQ-012 The block SHALL have port PC_out  output  32  address of Instruction_out plus 1.
REQ-013 The block SHALL have port Valid_out  output  1  Instruction_out/PC_out valid.
REQ-014 The block SHALL have port Flush_out  output  1  one-cycle pulse, registered, on every accepted Branch_Taken.

Function
REQ-015 The block SHALL implement states IDLE, REQ, OUT and DROP.
REQ-016 The block SHALL address memory in word units; the next PC SHALL be PC+1, modulo 2^32, so 32'hFFFFFFFF wraps to 0.
REQ-017 In IDLE the block SHALL keep Mem_Req=0 and SHALL move to REQ on the first clock edge after reset release.
REQ-018 In REQ the block SHALL hold Mem_Req=1, with Mem_Address equal to the PC and stable until Mem_Ready.
REQ-019 In REQ, on Mem_Ready=1 with Branch_Taken=0, the block SHALL do all of the following:
- capture Mem_Instruction into Instruction_out;
- set PC_out=Mem_Address+1;
- set Valid_out=1;
- advance the PC to Mem_Address+1;
- set Mem_Req=0;
- go to OUT.
REQ-020 In OUT the block SHALL hold Mem_Req=0 and keep its outputs stable while Freeze=1.
REQ-021 In OUT with Freeze=0, the block SHALL clear Valid_out and go to REQ, giving a fetch period of memory latency + 1 cycles.
REQ-022 Branch_Taken SHALL have priority over Mem_Ready and Freeze in every state.
REQ-023 On Branch_Taken the block SHALL load the PC from Branch_Address, clear Valid_out next cycle, and pulse Flush_out.
REQ-024 On Branch_Taken in IDLE or OUT, the block SHALL go to REQ with Mem_Address=Branch_Address.
REQ-025 On Branch_Taken in REQ with Mem_Ready=1 in the same cycle, the block SHALL discard the data and stay in REQ with Mem_Address=Branch_Address.
REQ-026 On Branch_Taken in REQ with Mem_Ready=0, the block SHALL go to DROP with Mem_Req=1 and Mem_Address unchanged.
REQ-027 In DROP, data returned with Mem_Ready SHALL be discarded, and the block SHALL then go to REQ with Mem_Address equal to the current PC.
REQ-028 On Branch_Taken in DROP, the block SHALL overwrite the PC and remain in DROP, so the last redirect wins.
REQ-029 Mem_Ready while Mem_Req=0 SHALL be ignored.

Reset
REQ-030 On rst=0, asynchronously, the block SHALL set the state to IDLE and the PC and Mem_Address to RESET_PC.
REQ-031 On rst=0, asynchronously, the block SHALL clear Mem_Req, Valid_out, Flush_out, Instruction_out and PC_out to 0.
REQ-032 Reset mid-request SHALL abandon the request; a Mem_Ready arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-033 With macro FETCH_CTRL_PERF_EN defined, the block SHALL add output Bubble_Count[15:0].
REQ-034 Bubble_Count SHALL count cycles with Valid_out=0 after reset release, saturate at 16'hFFFF, and reset to 0.
REQ-035 Without FETCH_CTRL_PERF_EN, the port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-036 Scenario: reset release, memory ready after 2 cycles, Freeze=0 -> Mem_Address sequence 0,1,2; Instruction_out matches; PC_out=1,2,3; Valid_out high for 1 cycle every 3 cycles.
REQ-037 Scenario: Freeze=1 for 5 cycles while Valid_out=1 -> Mem_Req stays 0 and Instruction_out/PC_out are unchanged; the next request issues 1 cycle after Freeze falls.
REQ-038 Scenario: Branch_Taken with Branch_Address=32'h40 while REQ is waiting at address 3 -> Flush_out pulses, DROP holds address 3, returned data is discarded, next Mem_Address=32'h40, and the next Valid_out has PC_out=32'h41.
REQ-039 Scenario: Branch_Taken coincident with Mem_Ready -> no Valid_out for the old data, and Mem_Address=Branch_Address on the next cycle.
REQ-040 Scenario: RESET_PC=32'hFFFFFFFF, one fetch -> PC_out=0 and the next Mem_Address=0.
REQ-041 Scenario: rst asserted mid-request, then released -> all outputs 0 immediately, then a fresh request at RESET_PC; with FETCH_CTRL_PERF_EN, Bubble_Count restarts from 0.

Source files
------------

// File: rtl/fetch_controller.sv
// Word-addressed instruction fetch FSM with branch redirect, flush pulse and squash of in-flight reads.
// Optional FETCH_CTRL_PERF_EN adds a saturating Bubble_Count of cycles with Valid_out low.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Freeze,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Address,
    input  logic        Mem_Ready,
    input  logic [31:0] Mem_Instruction,
    output logic        Mem_Req,
    output logic [31:0] Mem_Address,
    output logic [31:0] Instruction_out,
    output logic [31:0] PC_out,
    output logic        Valid_out,
    output logic        Flush_out
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [15:0] Bubble_Count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        OUT,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        valid_d = valid_q;
        flush_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = pc_q;
                if (Branch_Taken) begin
                    pc_d    = Branch_Address;
                    addr_d  = Branch_Address;
                    flush_d = 1'b1;
                end
            end
            REQ: begin
                if (Branch_Taken) begin
                    pc_d    = Branch_Address;
                    flush_d = 1'b1;
                    valid_d = 1'b0;
                    // A read still in flight must be drained before re-issuing
                    if (Mem_Ready) addr_d = Branch_Address;
                    else state_d = DROP;
                end else if (Mem_Ready) begin
                    instr_d = Mem_Instruction;
                    pcout_d = addr_q + 32'd1;
                    pc_d    = addr_q + 32'd1;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (Branch_Taken) begin
                    pc_d    = Branch_Address;
                    addr_d  = Branch_Address;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    flush_d = 1'b1;
                    state_d = REQ;
                end else if (!Freeze) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (Branch_Taken) begin
                    pc_d    = Branch_Address;
                    flush_d = 1'b1;
                end else if (Mem_Ready) begin
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            instr_q <= 32'd0;
            pcout_q <= 32'd0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    assign Mem_Req         = req_q;
    assign Mem_Address     = addr_q;
    assign Instruction_out = instr_q;
    assign PC_out          = pcout_q;
    assign Valid_out       = valid_q;
    assign Flush_out       = flush_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (!valid_q && bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bubble_q <= 16'd0;
        else bubble_q <= bubble_d;
    end

    assign Bubble_Count = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: memory responder, redirects, freeze, reset.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Freeze = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [31:0] Branch_Address = 32'd0;
    logic        Mem_Ready = 1'b0;
    logic [31:0] Mem_Instruction = 32'd0;
    logic        Mem_Req;
    logic [31:0] Mem_Address, Instruction_out, PC_out;
    logic        Valid_out, Flush_out;
    logic        w_req, w_valid, w_flush;
    logic [31:0] w_addr, w_instr, w_pc;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] Bubble_Count, w_bubble;
`endif

    fetch_controller u_dut (
        .clk(clk), .rst(rst), .Freeze(Freeze),
        .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address),
        .Mem_Ready(Mem_Ready), .Mem_Instruction(Mem_Instruction),
        .Mem_Req(Mem_Req), .Mem_Address(Mem_Address),
        .Instruction_out(Instruction_out), .PC_out(PC_out),
        .Valid_out(Valid_out), .Flush_out(Flush_out)
`ifdef FETCH_CTRL_PERF_EN
        , .Bubble_Count(Bubble_Count)
`endif
    );

    fetch_controller #(.RESET_PC(32'hFFFFFFFF)) u_wrap (
        .clk(clk), .rst(rst), .Freeze(Freeze),
        .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address),
        .Mem_Ready(Mem_Ready), .Mem_Instruction(Mem_Instruction),
        .Mem_Req(w_req), .Mem_Address(w_addr),
        .Instruction_out(w_instr), .PC_out(w_pc),
        .Valid_out(w_valid), .Flush_out(w_flush)
`ifdef FETCH_CTRL_PERF_EN
        , .Bubble_Count(w_bubble)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   lat = 0;
    int   lat_need = 2;
    logic drop_m = 1'b0;
    logic spur = 1'b0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive, cross one posedge, land on the next negedge.
    task automatic tick(input logic bt, input logic [31:0] ba,
                        input logic frz);
        logic rdy;
        logic kept;
        exp_t e;
        Branch_Taken   = bt;
        Branch_Address = ba;
        Freeze         = frz;
        rdy = 1'b0;
        if (Mem_Req) begin
            if (lat == lat_need - 1) begin
                rdy = 1'b1;
                lat = 0;
            end else lat++;
        end else lat = 0;
        Mem_Ready       = rdy | spur;
        Mem_Instruction = mdata(Mem_Address);
        if (rdy && !bt && !drop_m) sb.push_back({Mem_Address + 32'd1,
                                                 mdata(Mem_Address)});
        if (drop_m && rdy && !bt) drop_m = 1'b0;
        if (bt && Mem_Req && !rdy) drop_m = 1'b1;
        kept = Valid_out && frz && !bt;
        @(posedge clk);
        @(negedge clk);
        if (Valid_out && !kept) begin
            if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("sb_pc", PC_out, e.pc);
                chk("sb_ins", Instruction_out, e.ins);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        logic [31:0] held;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", Mem_Req, 0);
        chk("rst_addr", Mem_Address, 0);
        chk("rst_valid", Valid_out, 0);
        chk("rst_flush", Flush_out, 0);
        chk("rst_ins", Instruction_out, 0);
        chk("rst_pc", PC_out, 0);
        chk("rst_waddr", w_addr, 32'hFFFFFFFF);
        rst = 1'b1;
        tick(0, 0, 0);
        nv = 0;
        for (int k = 0; k < 3; k++) begin
            chk("seq_addr", Mem_Address, k);
            chk("seq_req", Mem_Req, 1);
            nv += int'(Valid_out);
            tick(0, 0, 0);
            nv += int'(Valid_out);
            tick(0, 0, 0);
            nv += int'(Valid_out);
            chk("seq_outreq", Mem_Req, 0);
            if (k == 0) chk("wrap_pc", w_pc, 0);
            tick(0, 0, 0);
            if (k == 0) chk("wrap_addr", w_addr, 0);
        end
        chk("seq_nvalid", nv, 3);
        // redirect while waiting at address 3
        chk("br_pre", Mem_Address, 3);
        tick(1, 32'h40, 0);
        chk("br_flush", Flush_out, 1);
        chk("br_dropreq", Mem_Req, 1);
        chk("br_dropaddr", Mem_Address, 3);
        tick(0, 0, 0);
        chk("br_flush0", Flush_out, 0);
        chk("br_newaddr", Mem_Address, 32'h40);
        chk("br_novalid", Valid_out, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("br_pcout", PC_out, 32'h41);
        tick(0, 0, 0);
        // freeze
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("frz_valid0", Valid_out, 1);
        held = mdata(32'h41);
        for (int i = 0; i < 5; i++) begin
            spur = (i == 2);
            tick(0, 0, 1);
            chk("frz_req", Mem_Req, 0);
            chk("frz_valid", Valid_out, 1);
            chk("frz_pc", PC_out, 32'h42);
            chk("frz_ins", Instruction_out, held);
        end
        spur = 1'b0;
        tick(0, 0, 0);
        chk("frz_rel_req", Mem_Req, 1);
        chk("frz_rel_addr", Mem_Address, 32'h42);
        // redirect coincident with Mem_Ready
        tick(0, 0, 0);
        tick(1, 32'h80, 0);
        chk("co_valid", Valid_out, 0);
        chk("co_addr", Mem_Address, 32'h80);
        chk("co_flush", Flush_out, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("co_pcout", PC_out, 32'h81);
        // redirect from OUT, then two redirects in DROP
        tick(1, 32'h100, 0);
        chk("out_br_addr", Mem_Address, 32'h100);
        chk("out_br_valid", Valid_out, 0);
        lat_need = 4;
        tick(1, 32'h200, 0);
        tick(1, 32'h300, 0);
        chk("drop_flush", Flush_out, 1);
        chk("drop_addr", Mem_Address, 32'h100);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("drop_last", Mem_Address, 32'h300);
        lat_need = 2;
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("drop_pcout", PC_out, 32'h301);
        tick(0, 0, 0);
        // asynchronous reset mid-request
        #2 rst = 1'b0;
        #1;
        chk("ar_req", Mem_Req, 0);
        chk("ar_addr", Mem_Address, 0);
        chk("ar_valid", Valid_out, 0);
        chk("ar_pc", PC_out, 0);
        chk("ar_ins", Instruction_out, 0);
`ifdef FETCH_CTRL_PERF_EN
        chk("ar_bubble", Bubble_Count, 0);
`endif
        drop_m = 1'b0;
        lat = 0;
        @(negedge clk);
        rst = 1'b1;
        spur = 1'b1;
        tick(0, 0, 0);
        spur = 1'b0;
        chk("post_req", Mem_Req, 1);
        chk("post_addr", Mem_Address, 0);
        chk("post_valid", Valid_out, 0);
`ifdef FETCH_CTRL_PERF_EN
        chk("post_bubble", Bubble_Count, 1);
`endif
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("post_pcout", PC_out, 1);
`ifdef FETCH_CTRL_PERF_EN
        chk("post_bubble3", Bubble_Count, 3);
`endif
        chk("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
